// File: rtl/regs_param_sb.sv
// regs_param_sb: 2R/1W register file with byte-enable writes, write-to-read bypass and busy scoreboard
module regs_param_sb #(
  parameter int DW = 32,
  parameter int AW = 3,
  parameter bit ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            cr,
  input  logic [AW-1:0]   Addr_A,
  input  logic [AW-1:0]   Addr_B,
  output logic [DW-1:0]   QA,
  output logic [DW-1:0]   QB,
  output logic            busy_A,
  output logic            busy_B,
  input  logic            WE,
  input  logic [AW-1:0]   Addr_W,
  input  logic [DW-1:0]   Di,
  input  logic [DW/8-1:0] BE,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ok
);
  localparam int N = 2**AW;
  logic [DW-1:0] mem [N];
  logic [N-1:0] busy, busy_nxt;
  logic [DW-1:0] bmask;
  logic wr_a, wr_b, zero_rsv;
  for (genvar i = 0; i < DW/8; i++) assign bmask[8*i+:8] = {8{BE[i]}};
  assign wr_a = WE && Addr_W == Addr_A;
  assign wr_b = WE && Addr_W == Addr_B;
  assign QA = (ZERO_R0 && Addr_A == '0) ? '0 : wr_a ? (mem[Addr_A] & ~bmask) | (Di & bmask) : mem[Addr_A];
  assign QB = (ZERO_R0 && Addr_B == '0) ? '0 : wr_b ? (mem[Addr_B] & ~bmask) | (Di & bmask) : mem[Addr_B];
  assign busy_A = busy[Addr_A] & ~wr_a;
  assign busy_B = busy[Addr_B] & ~wr_b;
  assign rsv_ok = rsv_en & (~busy[rsv_addr] | (WE && Addr_W == rsv_addr));
  assign zero_rsv = ZERO_R0 && rsv_addr == '0;
  // reservation is applied after the writeback clear so it wins on the same address
  always_comb begin
    busy_nxt = busy;
    if (WE) busy_nxt[Addr_W] = 1'b0;
    if (rsv_ok && !zero_rsv) busy_nxt[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      busy <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      busy <= busy_nxt;
      if (WE && !(ZERO_R0 && Addr_W == '0)) mem[Addr_W] <= (mem[Addr_W] & ~bmask) | (Di & bmask);
    end
  end
endmodule
